// File: rtl/garota_pkg.sv
// Shared GAROTA definitions: FSM encoding, violation source indices, TCB window helper.
// Purely combinational content; no latency or backpressure applies.
package garota_pkg;

    localparam int GAROTA_NUM_SRC = 7;

    localparam int SRC_PMEM  = 0;
    localparam int SRC_UART  = 1;
    localparam int SRC_TIMER = 2;
    localparam int SRC_GPIO  = 3;
    localparam int SRC_ATOM  = 4;
    localparam int SRC_IRQ   = 5;
    localparam int SRC_GIE   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_WAIT = 2'd2
    } rst_state_t;

    // Inclusive window [base, base+size], evaluated in 17 bits so the end never wraps.
    function automatic logic in_window(input logic [15:0] pc,
                                       input logic [15:0] base,
                                       input logic [15:0] size);
        logic [16:0] hi;
        hi = {1'b0, base} + {1'b0, size};
        return (pc >= base) && ({1'b0, pc} <= hi);
    endfunction

endpackage

// File: rtl/garota_sat_counter.sv
// Saturating up/down counter with synchronous load; load wins over inc/dec.
// Latency: one clock from control to count; no backpressure, sticks at 0 or all-ones.
module garota_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && !dec && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end else if (dec && !inc && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

endmodule

// File: rtl/garota_reset_ctrl.sv
// Violation-reset consumer: holds the core in reset, records sticky cause, counts episodes.
// Latency: core_rst rises one edge after a violation; no backpressure, viol is sampled every cycle.
module garota_reset_ctrl
    import garota_pkg::*;
#(
    parameter logic [15:0] RESET_HANDLER = 16'h0000,
    parameter logic [15:0] TCB_BASE      = 16'hFAE0,
    parameter logic [15:0] TCB_SIZE      = 16'h03FC,
    parameter int          HOLD_CYCLES   = 8,
    parameter int          WAIT_TIMEOUT  = 16,
    parameter int          NUM_SRC       = GAROTA_NUM_SRC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] viol,
    input  logic [15:0]        pc,
    input  logic               cause_clr,
    output logic               core_rst,
    output logic [NUM_SRC-1:0] cause,
    output logic [7:0]         viol_cnt,
    output logic               busy
);

    localparam int              CNT_W     = 16;
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_TIMEOUT - 1);

    rst_state_t         state_q, state_nxt;
    logic [CNT_W-1:0]   hold_cnt, wait_cnt;
    logic               hold_load, hold_dec;
    logic               wait_load, wait_dec;
    logic               episode;
    logic               any_viol;
    logic               clr_ok;
    logic [NUM_SRC-1:0] cause_q, cause_nxt;
    logic               core_rst_q, busy_q;

    assign any_viol = |viol;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        wait_load = 1'b0;
        wait_dec  = 1'b0;
        episode   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_viol) begin
                    state_nxt = ST_HOLD;
                    hold_load = 1'b1;
                    episode   = 1'b1;
                end
            end
            ST_HOLD: begin
                if (hold_cnt == '0) begin
                    state_nxt = ST_WAIT;
                    wait_load = 1'b1;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            ST_WAIT: begin
                // A fresh violation outranks a handler fetch in the same cycle.
                if (any_viol) begin
                    state_nxt = ST_HOLD;
                    hold_load = 1'b1;
                    episode   = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    state_nxt = ST_IDLE;
                end else if (wait_cnt == '0) begin
                    state_nxt = ST_HOLD;
                    hold_load = 1'b1;
                    episode   = 1'b1;
                end else begin
                    wait_dec = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Only TCB code running while idle may wipe the cause; bits arriving in that cycle survive.
    assign clr_ok    = cause_clr && (state_q == ST_IDLE) && in_window(pc, TCB_BASE, TCB_SIZE);
    assign cause_nxt = (clr_ok ? '0 : cause_q) | viol;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_q    <= '0;
            core_rst_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            cause_q    <= cause_nxt;
            core_rst_q <= (state_nxt == ST_HOLD);
            busy_q     <= (state_nxt != ST_IDLE);
        end
    end

    garota_sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (hold_load),
        .load_val (HOLD_LOAD),
        .inc      (1'b0),
        .dec      (hold_dec),
        .cnt      (hold_cnt)
    );

    garota_sat_counter #(.W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load),
        .load_val (WAIT_LOAD),
        .inc      (1'b0),
        .dec      (wait_dec),
        .cnt      (wait_cnt)
    );

    garota_sat_counter #(.W(8)) u_viol_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .load_val (8'h00),
        .inc      (episode),
        .dec      (1'b0),
        .cnt      (viol_cnt)
    );

    assign core_rst = core_rst_q;
    assign cause    = cause_q;
    assign busy     = busy_q;

endmodule
